// File: rtl/line_array_axi_pkg.sv
// line_array_axi_pkg: register offsets, response codes and FSM state types for line_array_axi_regs
package line_array_axi_pkg;
  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/line_array_strb_merge.sv
// line_array_strb_merge: byte-lane merge of write data into an existing word
module line_array_strb_merge #(
  parameter int W = 32
) (
  input  logic [W-1:0]   old_i,
  input  logic [W-1:0]   data_i,
  input  logic [W/8-1:0] strb_i,
  output logic [W-1:0]   new_o
);
  for (genvar b = 0; b < W / 8; b++) begin : g_lane
    assign new_o[8*b +: 8] = strb_i[b] ? data_i[8*b +: 8] : old_i[8*b +: 8];
  end
endmodule

// File: rtl/line_array_axi_regs.sv
// line_array_axi_regs: AXI4-Lite slave with four 32-bit line-array control registers.
// Define LINE_ARRAY_AXI_REGS_SLVERR_EN to reject accesses above offset 0x0C with SLVERR.
module line_array_axi_regs
  import line_array_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  w_state_e      w_q, w_d;
  r_state_e      r_q, r_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d, merged;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [1:0]    wsel, rsel;
  logic          w_hs, r_hs, aw_err, ar_err, unused_ok;
  assign wsel = S_AXI_AWADDR[3:2];
  assign rsel = S_AXI_ARADDR[3:2];
`ifdef LINE_ARRAY_AXI_REGS_SLVERR_EN
  assign aw_err = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
  assign ar_err = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};
  // Ready is a same-cycle acknowledge so the handshake, update and state move share one edge.
  assign w_hs = S_AXI_ARESETN && w_q == W_IDLE && S_AXI_AWVALID && S_AXI_WVALID;
  assign r_hs = S_AXI_ARESETN && r_q == R_IDLE && S_AXI_ARVALID;
  assign S_AXI_AWREADY = w_hs;
  assign S_AXI_WREADY  = w_hs;
  assign S_AXI_ARREADY = r_hs;
  assign S_AXI_BVALID  = w_q == W_RESP;
  assign S_AXI_RVALID  = r_q == R_DATA;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];
  line_array_strb_merge #(.W(DW)) u_merge (
    .old_i  (regs_q[wsel]),
    .data_i (S_AXI_WDATA),
    .strb_i (S_AXI_WSTRB),
    .new_o  (merged)
  );
  // Read data is taken from regs_q, so a same-edge write is not visible to the read.
  always_comb begin
    w_d     = w_q;
    r_d     = r_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    rdata_d = rdata_q;
    regs_d  = regs_q;
    if (w_hs) begin
      w_d     = W_RESP;
      bresp_d = aw_err ? RESP_SLVERR : RESP_OKAY;
      if (!aw_err) regs_d[wsel] = merged;
    end else if (w_q == W_RESP && S_AXI_BREADY) begin
      w_d = W_IDLE;
    end
    if (r_hs) begin
      r_d     = R_DATA;
      rresp_d = ar_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d = ar_err ? '0 : regs_q[rsel];
    end else if (r_q == R_DATA && S_AXI_RREADY) begin
      r_d = R_IDLE;
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_q     <= W_IDLE;
      r_q     <= R_IDLE;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
      regs_q  <= '{default: '0};
    end else begin
      w_q     <= w_d;
      r_q     <= r_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      regs_q  <= regs_d;
    end
  end
endmodule

// File: tb/tb_line_array_axi_regs.sv
// tb_line_array_axi_regs: directed, table-driven checks of the line-array AXI4-Lite register block
module tb_line_array_axi_regs;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, reg0, reg1, reg2, reg3;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  line_array_axi_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3)
  );
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] reg_out(input int i);
    return i == 0 ? reg0 : i == 1 ? reg1 : i == 2 ? reg2 : reg3;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    if (n >= 20) chk("write_handshake_timeout", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("bvalid_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask
  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("read_handshake_timeout", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("rvalid_timeout", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask
  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    vecs[0] = '{6'h00, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
    vecs[1] = '{6'h04, 32'hABCD0001, 4'hF, 32'hABCD0001};
    vecs[2] = '{6'h08, 32'hDEAD0011, 4'hF, 32'hDEAD0011};
    vecs[3] = '{6'h0C, 32'hBEEF0011, 4'hF, 32'hBEEF0011};
    vecs[4] = '{6'h04, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[5] = '{6'h04, 32'h12345678, 4'b0101, 32'hFF34FF78};
    vecs[6] = '{6'h0C, 32'h00000000, 4'h0, 32'hBEEF0011};
    vecs[7] = '{6'h08, 32'h11223344, 4'b1000, 32'h11AD0011};
    repeat (3) @(posedge clk);
    #1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_reg%0d", i), reg_out(i), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
      chk($sformatf("v%0d_bresp", i), 32'(r), 32'd0);
      chk($sformatf("v%0d_reg_o", i), reg_out(int'(vecs[i].addr[3:2])), vecs[i].exp);
      axi_read(vecs[i].addr, d, r);
      chk($sformatf("v%0d_rdata", i), d, vecs[i].exp);
      chk($sformatf("v%0d_rresp", i), 32'(r), 32'd0);
      if (i == 3)
        for (int k = 0; k < 4; k++) chk($sformatf("v3_reg%0d_o", k), reg_out(k), vecs[k].exp);
    end
    awaddr = 6'h00; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("aw_only_awready_%0d", i), 32'(awready), 32'd0);
      chk($sformatf("aw_only_wready_%0d", i), 32'(wready), 32'd0);
      tick();
    end
    wvalid = 1'b1;
    #1;
    chk("both_valid_ready", 32'({awready, wready}), 32'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("reg0_after_hs", reg0, 32'h5A5A5A5A);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bhold_bvalid_%0d", i), 32'(bvalid), 32'd1);
      chk($sformatf("bhold_bresp_%0d", i), 32'(bresp), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_released", 32'(bvalid), 32'd0);
    axi_write(6'h08, 32'h0, 4'hF, r);
    awaddr = 6'h08; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    #1;
    chk("same_edge_ready", 32'({awready, arready}), 32'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_rvalid", 32'({rvalid, bvalid}), 32'b11);
    chk("same_edge_rdata_old", rdata, 32'h0);
    chk("same_edge_reg2_o", reg2, 32'hA5A5A5A5);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    axi_read(6'h08, d, r);
    chk("same_edge_reread", d, 32'hA5A5A5A5);
    axi_write(6'h10, 32'h77777777, 4'hF, r);
`ifdef LINE_ARRAY_AXI_REGS_SLVERR_EN
    chk("hi_bresp", 32'(r), 32'h2);
    chk("hi_reg0_kept", reg0, 32'h5A5A5A5A);
    axi_read(6'h10, d, r);
    chk("hi_rdata", d, 32'h0);
    chk("hi_rresp", 32'(r), 32'h2);
`else
    chk("hi_bresp", 32'(r), 32'h0);
    chk("hi_reg0_alias", reg0, 32'h77777777);
    axi_read(6'h10, d, r);
    chk("hi_rdata", d, 32'h77777777);
    chk("hi_rresp", 32'(r), 32'h0);
`endif
    awaddr = 6'h04; wdata = 32'h00000001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_bvalid", 32'(bvalid), 32'd1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("mid_rst_reg%0d", i), reg_out(i), 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_bvalid", 32'(bvalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(4 * i), d, r);
      chk($sformatf("post_rst_read%0d", i), d, 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/line_array_axi_regs.md
LINE_ARRAY_AXI_REGS -- requirements
Module: line_array_axi_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 S_AXI_ACLK  in  1  single clock; all logic samples on its rising edge.
REQ-004 S_AXI_ARESETN  in  1  reset, synchronous and active-low.
REQ-005 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored.
REQ-006 S_AXI_AWVALID  in  1, S_AXI_AWREADY  out  1  write-address handshake.
REQ-007 S_AXI_WDATA  in  32, S_AXI_WSTRB  in  4, S_AXI_WVALID  in  1, S_AXI_WREADY  out  1  write-data channel.
REQ-008 S_AXI_BRESP  out  2, S_AXI_BVALID  out  1, S_AXI_BREADY  in  1  write-response channel.
REQ-009 S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH, S_AXI_ARPROT  in  3 (ignored), S_AXI_ARVALID  in  1, S_AXI_ARREADY  out  1  read-address channel.
REQ-010 S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1, S_AXI_RREADY  in  1  read-data channel.
REQ-011 reg0_o..reg3_o  out  32 each  current contents of registers 0..3, driven to the line-array logic.

Function
REQ-012 Four 32-bit read/write registers at byte offsets 0x00, 0x04, 0x08 and 0x0C, selected by address bits [3:2].
REQ-013 Write FSM states: W_IDLE and W_RESP.
REQ-014 In W_IDLE, when AWVALID and WVALID are both 1, AWREADY and WREADY SHALL pulse high together for exactly one cycle; the register update and the move to W_RESP happen on that same edge.
REQ-015 A write with only one of AWVALID/WVALID high SHALL NOT be accepted; both READY signals stay 0.
REQ-016 Byte lane n of the selected register SHALL update only if WSTRB[n]=1; WSTRB=0 leaves the register unchanged but still produces a response.
REQ-017 BVALID SHALL assert the cycle after the handshake and hold, with BRESP stable, until BREADY=1; the FSM then returns to W_IDLE.
REQ-018 No new write SHALL be accepted while BVALID=1, so write throughput is at most one per two cycles.
REQ-019 Read FSM states: R_IDLE and R_DATA.
REQ-020 In R_IDLE with ARVALID=1, ARREADY SHALL pulse for one cycle; RDATA is captured on that edge and RVALID asserts the next cycle.
REQ-021 RVALID, RDATA and RRESP SHALL hold until RREADY=1; no new AR is accepted while RVALID=1.
REQ-022 Read and write FSMs SHALL be independent.
REQ-023 If a read and a write of the same register are accepted on the same edge, the read SHALL return the pre-write value.
REQ-024 reg*_o SHALL reflect a write on the cycle after the write handshake.

Reset
REQ-025 While ARESETN=0 at a clock edge, all registers SHALL clear to 0x00000000.
REQ-026 During reset, AWREADY, WREADY, BVALID, ARREADY and RVALID SHALL be 0, BRESP and RRESP SHALL be 00, and RDATA SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no response, return both FSMs to IDLE, and leave registers at zero.

Configuration
REQ-028 The macro LINE_ARRAY_AXI_REGS_SLVERR_EN controls decoding of address bits above [3:2].
REQ-029 With the macro defined, any access where addr[C_S_AXI_ADDR_WIDTH-1:4] != 0 SHALL return SLVERR (2'b10); such a write modifies no register and such a read returns RDATA=0.
REQ-030 Without the macro, the upper address bits SHALL be ignored (registers alias every 16 bytes) and every response SHALL be OKAY (2'b00).

Structure
REQ-031 Package line_array_axi_pkg SHALL hold the register offset constants, the RESP_OKAY and RESP_SLVERR codes, and the write and read FSM state enums.
REQ-032 One sub-module, line_array_strb_merge, SHALL be purely combinational: old word + WDATA + WSTRB -> new word.
REQ-033 The register file and both FSMs SHALL stay in line_array_axi_regs.

Verification
REQ-034 Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x00..0x0C, then read each back -> identical data with RRESP=OKAY, and reg0_o..reg3_o match.
REQ-035 Reg1 holds 0xFFFFFFFF; write 0x12345678 with WSTRB=4'b0101 -> readback 0xFF34FF78.
REQ-036 AWVALID raised 3 cycles before WVALID -> no READY until both are high; BREADY held low for 5 cycles -> BVALID and BRESP stay stable throughout.
REQ-037 Same-edge read and write of reg2 (old value 0x0, new value 0xA5A5A5A5) -> RDATA=0x0; a subsequent read returns 0xA5A5A5A5.
REQ-038 Access to 0x10: with SLVERR_EN, write gives BRESP=2'b10, reg0 is unchanged and read gives RDATA=0 with RRESP=2'b10; without the macro, the write updates reg0 and responses are OKAY.
REQ-039 Reset pulsed while BVALID=1 -> BVALID=0 and all registers read 0x00000000 afterwards.
